// File: rtl/motor_if_pkg.sv
// Shared definitions for the motor-side speed-loop interface.
//   DUTY_W_DEF / SPEED_W_DEF : default widths of the duty word and speed sample
//   step_e                   : one-cycle quadrature decode result
//   sat_clamp                : clamp a signed value into a signed field of given width
package motor_if_pkg;

    localparam int unsigned DUTY_W_DEF  = 8;
    localparam int unsigned SPEED_W_DEF = 8;

    typedef enum logic [1:0] {
        STEP_NONE = 2'b00,
        STEP_FWD  = 2'b01,
        STEP_REV  = 2'b10,
        STEP_ERR  = 2'b11
    } step_e;

    // Clamp val to [-2**(width-1), 2**(width-1)-1]; caller keeps the low width bits.
    function automatic logic signed [31:0] sat_clamp(input logic signed [31:0] val,
                                                     input int unsigned         width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 1));
        if (val > hi) begin
            return hi;
        end else if (val < lo) begin
            return lo;
        end
        return val;
    endfunction

endpackage

// File: rtl/quad_decoder.sv
// Quadrature encoder front end.
//   clk, reset    : system clock, synchronous active-high reset
//   enc_a_i/b_i   : asynchronous encoder channels
//   step_o        : combinational step decoded from history vs. synchronized value
//   enc_err_o     : registered 1-cycle pulse when both channels changed at once
module quad_decoder
    import motor_if_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  enc_a_i,
    input  logic  enc_b_i,
    output step_e step_o,
    output logic  enc_err_o
);

    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] hist_q;
    logic       enc_err_q;

    // Two-flop synchronizer followed by one history stage; step compares the
    // last two synchronized samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 2'b00;
            sync2_q   <= 2'b00;
            hist_q    <= 2'b00;
            enc_err_q <= 1'b0;
        end else begin
            sync1_q   <= {enc_a_i, enc_b_i};
            sync2_q   <= sync1_q;
            hist_q    <= sync2_q;
            enc_err_q <= (step_o == STEP_ERR);
        end
    end

    // {a,b} forward Gray order: 00 -> 01 -> 11 -> 10 -> 00
    always_comb begin
        step_o = STEP_NONE;
        case ({hist_q, sync2_q})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_o = STEP_FWD;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_o = STEP_REV;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: step_o = STEP_ERR;
            default:                                step_o = STEP_NONE;
        endcase
    end

    assign enc_err_o = enc_err_q;

endmodule

// File: rtl/motor_pwm_speed_if.sv
// Motor-side end of the speed loop: PWM generator with shadowed duty word and
// windowed quadrature speed measurement.
//   clk, reset        : system clock, synchronous active-high reset
//   duty_in/valid     : duty request from the PID stage, 1-cycle qualifier
//   pwm_out           : registered PWM drive to the bridge
//   pwm_period_start  : 1-cycle pulse marking the start of each PWM period
//   enc_a, enc_b      : asynchronous encoder channels
//   speed             : signed edges per window, saturated to SPEED_W
//   speed_valid       : 1-cycle pulse when speed updates
//   speed_sat         : last window was clipped
//   dir               : last window net forward (speed >= 0)
//   enc_err           : 1-cycle pulse on illegal quadrature transition
module motor_pwm_speed_if
    import motor_if_pkg::*;
#(
    parameter int unsigned DUTY_W       = DUTY_W_DEF,
    parameter int unsigned PWM_PRESCALE = 4,
    parameter int unsigned SPEED_WINDOW = 50000,
    parameter int unsigned SPEED_W      = SPEED_W_DEF,
    parameter int unsigned ACC_W        = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DUTY_W-1:0]  duty_in,
    input  logic               duty_valid,
    output logic               pwm_out,
    output logic               pwm_period_start,
    input  logic               enc_a,
    input  logic               enc_b,
    output logic [SPEED_W-1:0] speed,
    output logic               speed_valid,
    output logic               speed_sat,
    output logic               dir,
    output logic               enc_err
);

    localparam int unsigned PRESC_W = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
    localparam int unsigned WIN_W   = $clog2(SPEED_WINDOW);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PWM_PRESCALE - 1);
    localparam logic [DUTY_W-1:0]  CNT_LAST   = DUTY_W'((2 ** DUTY_W) - 2);
    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(SPEED_WINDOW - 1);

    // ---------------------------------------------------------------- PWM
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [DUTY_W-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic [DUTY_W-1:0]  duty_pending_q, duty_pending_d;
    logic [DUTY_W-1:0]  duty_active_q, duty_active_d;
    logic               started_q;
    logic               pwm_out_q, pwm_out_d;
    logic               period_start_q;
    logic               tick, wrap, boundary;

    always_comb begin
        tick     = (presc_q == PRESC_LAST);
        wrap     = tick && (pwm_cnt_q == CNT_LAST);
        // The first cycle after reset acts as a boundary so a fresh period
        // begins with count 0 and the pending duty latched.
        boundary = !started_q || wrap;

        presc_d   = tick ? '0 : presc_q + PRESC_W'(1);
        pwm_cnt_d = pwm_cnt_q;
        if (tick) begin
            pwm_cnt_d = wrap ? '0 : pwm_cnt_q + DUTY_W'(1);
        end
        if (!started_q) begin
            presc_d   = '0;
            pwm_cnt_d = '0;
        end

        // A write in the boundary cycle itself bypasses the shadow register.
        duty_pending_d = duty_valid ? duty_in : duty_pending_q;
        duty_active_d  = boundary ? duty_pending_d : duty_active_q;

        pwm_out_d = (pwm_cnt_d < duty_active_d);
    end

    // ------------------------------------------------------- speed window
    step_e                     step;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [ACC_W-1:0]   step_val;
    logic signed [ACC_W:0]     acc_sum;
    logic signed [ACC_W-1:0]   acc_next;
    logic signed [31:0]        acc_sat;
    logic signed [31:0]        spd_wide;
    logic [WIN_W-1:0]          win_q, win_d;
    logic [SPEED_W-1:0]        speed_q, speed_d;
    logic                      speed_valid_q, speed_valid_d;
    logic                      speed_sat_q, speed_sat_d;
    logic                      dir_q, dir_d;
    logic                      terminal;

    quad_decoder u_quad_decoder (
        .clk       (clk),
        .reset     (reset),
        .enc_a_i   (enc_a),
        .enc_b_i   (enc_b),
        .step_o    (step),
        .enc_err_o (enc_err)
    );

    always_comb begin
        case (step)
            STEP_FWD: step_val = ACC_W'(1);
            STEP_REV: step_val = '1;
            default:  step_val = '0;
        endcase

        // One guard bit so the sum never wraps before saturation.
        acc_sum  = {acc_q[ACC_W-1], acc_q} + {step_val[ACC_W-1], step_val};
        acc_sat  = sat_clamp(32'(acc_sum), ACC_W);
        acc_next = acc_sat[ACC_W-1:0];
        spd_wide = sat_clamp(32'(acc_next), SPEED_W);

        terminal      = (win_q == WIN_LAST);
        win_d         = terminal ? '0 : win_q + WIN_W'(1);
        acc_d         = acc_next;
        speed_d       = speed_q;
        speed_sat_d   = speed_sat_q;
        dir_d         = dir_q;
        speed_valid_d = 1'b0;

        // The step decoded in the terminal cycle closes into this window.
        if (terminal) begin
            acc_d         = '0;
            speed_d       = spd_wide[SPEED_W-1:0];
            speed_sat_d   = (spd_wide != 32'(acc_next));
            dir_d         = ~spd_wide[31];
            speed_valid_d = 1'b1;
        end
    end

    // ------------------------------------------------------------ state
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q        <= '0;
            pwm_cnt_q      <= '0;
            duty_pending_q <= '0;
            duty_active_q  <= '0;
            started_q      <= 1'b0;
            pwm_out_q      <= 1'b0;
            period_start_q <= 1'b0;
            win_q          <= '0;
            acc_q          <= '0;
            speed_q        <= '0;
            speed_valid_q  <= 1'b0;
            speed_sat_q    <= 1'b0;
            dir_q          <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            pwm_cnt_q      <= pwm_cnt_d;
            duty_pending_q <= duty_pending_d;
            duty_active_q  <= duty_active_d;
            started_q      <= 1'b1;
            pwm_out_q      <= pwm_out_d;
            period_start_q <= boundary;
            win_q          <= win_d;
            acc_q          <= acc_d;
            speed_q        <= speed_d;
            speed_valid_q  <= speed_valid_d;
            speed_sat_q    <= speed_sat_d;
            dir_q          <= dir_d;
        end
    end

    assign pwm_out          = pwm_out_q;
    assign pwm_period_start = period_start_q;
    assign speed            = speed_q;
    assign speed_valid      = speed_valid_q;
    assign speed_sat        = speed_sat_q;
    assign dir              = dir_q;

endmodule

// File: tb/tb_motor_pwm_speed_if.sv
// Bench for motor_pwm_speed_if: two instances (prescale 1 and 3) share stimulus
// and are checked every cycle against a cycle-index based reference model.
module tb_motor_pwm_speed_if;

    localparam int W      = 1000;
    localparam int PER    = 255;
    localparam int PRE_A  = 1;
    localparam int PRE_B  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] duty_in = 8'd0;
    logic       duty_valid = 1'b0;
    logic       enc_a = 1'b0;
    logic       enc_b = 1'b0;

    logic       pwm_a, ps_a, sv_a, sat_a, dir_a, err_a;
    logic [7:0] speed_a;
    logic       pwm_b, ps_b, sv_b, sat_b, dir_b, err_b;
    logic [7:0] speed_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    motor_pwm_speed_if #(
        .DUTY_W(8), .PWM_PRESCALE(PRE_A), .SPEED_WINDOW(W), .SPEED_W(8), .ACC_W(16)
    ) dut_a (
        .clk(clk), .reset(reset), .duty_in(duty_in), .duty_valid(duty_valid),
        .pwm_out(pwm_a), .pwm_period_start(ps_a), .enc_a(enc_a), .enc_b(enc_b),
        .speed(speed_a), .speed_valid(sv_a), .speed_sat(sat_a), .dir(dir_a), .enc_err(err_a)
    );

    motor_pwm_speed_if #(
        .DUTY_W(8), .PWM_PRESCALE(PRE_B), .SPEED_WINDOW(W), .SPEED_W(8), .ACC_W(16)
    ) dut_b (
        .clk(clk), .reset(reset), .duty_in(duty_in), .duty_valid(duty_valid),
        .pwm_out(pwm_b), .pwm_period_start(ps_b), .enc_a(enc_a), .enc_b(enc_b),
        .speed(speed_b), .speed_valid(sv_b), .speed_sat(sat_b), .dir(dir_b), .enc_err(err_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int gray_pos(input logic [1:0] v);
        case (v)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] pos_ab(input int p);
        case (p)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    // ---------------------------------------------------- reference model
    // PWM: t = clk cycles since the period began; output high while the tick
    // index t/prescale is below the duty latched for that period.
    // Encoder: pin samples pass a 3-deep delay, each sample pair scores by its
    // Gray distance; window closes every W cycles after reset.
    bit         model_live = 1'b0;
    bit         m_first;
    int         m_t[2];
    int         m_duty[2];
    int         m_pend;
    bit         e_pwm[2];
    bit         e_ps[2];
    logic [1:0] q0, q1, q2;
    int         m_acc, m_win, e_speed;
    bit         e_sat, e_dir, e_sv, e_err;

    function automatic int pre_of(input int i);
        return (i == 0) ? PRE_A : PRE_B;
    endfunction

    task automatic model_step();
        int d;
        int step;
        bit bnd;
        if (reset) begin
            m_first = 1'b1;
            m_pend  = 0;
            for (int i = 0; i < 2; i++) begin
                m_t[i] = 0; m_duty[i] = 0; e_pwm[i] = 1'b0; e_ps[i] = 1'b0;
            end
            q0 = 2'b00; q1 = 2'b00; q2 = 2'b00;
            m_acc = 0; m_win = 0; e_speed = 0;
            e_sat = 1'b0; e_dir = 1'b0; e_sv = 1'b0; e_err = 1'b0;
            model_live = 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                bnd = m_first || (m_t[i] == pre_of(i) * PER - 1);
                if (bnd) begin
                    m_duty[i] = duty_valid ? int'(duty_in) : m_pend;
                    m_t[i]    = 0;
                end else begin
                    m_t[i]++;
                end
                e_ps[i]  = bnd;
                e_pwm[i] = (m_t[i] / pre_of(i)) < m_duty[i];
            end
            if (duty_valid) m_pend = int'(duty_in);
            m_first = 1'b0;

            d     = (gray_pos(q1) - gray_pos(q2) + 4) % 4;
            step  = (d == 1) ? 1 : (d == 3) ? -1 : 0;
            e_err = (d == 2);
            q2 = q1; q1 = q0; q0 = {enc_a, enc_b};

            m_acc = m_acc + step;
            if (m_acc > 32767)  m_acc = 32767;
            if (m_acc < -32768) m_acc = -32768;
            m_win++;
            if (m_win == W) begin
                m_win   = 0;
                e_speed = (m_acc > 127) ? 127 : (m_acc < -128) ? -128 : m_acc;
                e_sat   = (e_speed != m_acc);
                e_dir   = (e_speed >= 0);
                e_sv    = 1'b1;
                m_acc   = 0;
            end else begin
                e_sv = 1'b0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ------------------------------------------------------ compare process
    initial forever begin
        @(negedge clk);
        if (model_live) begin
            chk("pwm_out_a", int'(pwm_a), int'(e_pwm[0]));
            chk("period_start_a", int'(ps_a), int'(e_ps[0]));
            chk("pwm_out_b", int'(pwm_b), int'(e_pwm[1]));
            chk("period_start_b", int'(ps_b), int'(e_ps[1]));
            chk("speed_a", int'($signed(speed_a)), e_speed);
            chk("speed_valid_a", int'(sv_a), int'(e_sv));
            chk("speed_sat_a", int'(sat_a), int'(e_sat));
            chk("dir_a", int'(dir_a), int'(e_dir));
            chk("enc_err_a", int'(err_a), int'(e_err));
            chk("speed_b", int'($signed(speed_b)), e_speed);
            chk("speed_valid_b", int'(sv_b), int'(e_sv));
            chk("speed_sat_b", int'(sat_b), int'(e_sat));
            chk("dir_b", int'(dir_b), int'(e_dir));
            chk("enc_err_b", int'(err_b), int'(e_err));
        end
    end

    // ------------------------------------------------------------ helpers
    // Count high cycles of instance A over one period; optional write at index wr_at.
    task automatic period(input int wr_at, input logic [7:0] v, output int hi);
        int n;
        hi = 0;
        n  = 0;
        while (ps_a !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("period_start_seen", int'(ps_a), 1);
        for (int i = 0; i < PER; i++) begin
            duty_valid = 1'b0;
            if (i == wr_at) begin
                duty_in    = v;
                duty_valid = 1'b1;
            end
            hi += int'(pwm_a);
            @(negedge clk);
        end
        duty_valid = 1'b0;
    endtask

    task automatic wait_sv();
        int n;
        n = 0;
        @(negedge clk);
        while (sv_a !== 1'b1 && n < 1100) begin
            @(negedge clk);
            n++;
        end
        chk("speed_valid_seen", int'(sv_a), 1);
    endtask

    task automatic quad(input int n, input bit fwd, input int gap);
        logic [1:0] ab;
        int p;
        for (int i = 0; i < n; i++) begin
            ab = {enc_a, enc_b};
            p  = gray_pos(ab);
            p  = fwd ? (p + 1) % 4 : (p + 3) % 4;
            ab = pos_ab(p);
            enc_a = ab[1];
            enc_b = ab[0];
            repeat (gap) @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ stimulus
    initial begin
        int hi;
        int errs;
        int bias;
        logic [1:0] ab;
        int r;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("first_boundary_a", int'(ps_a), 1);
        chk("first_boundary_b", int'(ps_b), 1);

        // PWM duty and shadow behaviour
        duty_in = 8'd64; duty_valid = 1'b1;
        @(negedge clk);
        duty_valid = 1'b0;
        period(-1, 8'd0, hi);   chk("duty64_high", hi, 64);
        period(10, 8'd200, hi); chk("midwrite_keeps64", hi, 64);
        period(-1, 8'd0, hi);   chk("duty200_high", hi, 200);
        period(254, 8'd30, hi); chk("boundary_write_prev", hi, 200);
        period(-1, 8'd0, hi);   chk("boundary_write_applied", hi, 30);
        period(254, 8'd0, hi);  chk("duty30_high", hi, 30);
        period(-1, 8'd0, hi);   chk("duty0_high", hi, 0);
        period(254, 8'd255, hi);
        period(-1, 8'd0, hi);   chk("duty255_high", hi, 255);
        period(254, 8'd200, hi);
        period(-1, 8'd0, hi);   chk("duty200_again", hi, 200);

        // Reset mid-period with duty 200 active
        repeat (50) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_pwm_a", int'(pwm_a), 0);
        chk("reset_speed_a", int'(speed_a), 0);
        chk("reset_ps_a", int'(ps_a), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("restart_boundary", int'(ps_a), 1);
        chk("restart_duty0", int'(pwm_a), 0);

        // Encoder windows
        wait_sv();
        quad(40, 1'b1, 4);
        wait_sv();
        chk("fwd40_speed", int'($signed(speed_a)), 40);
        chk("fwd40_dir", int'(dir_a), 1);
        chk("fwd40_sat", int'(sat_a), 0);
        @(negedge clk);
        chk("sv_one_cycle", int'(sv_a), 0);
        quad(40, 1'b0, 4);
        wait_sv();
        chk("rev40_speed", int'($signed(speed_a)), -40);
        chk("rev40_dir", int'(dir_a), 0);
        quad(200, 1'b1, 2);
        wait_sv();
        chk("fwd200_speed", int'($signed(speed_a)), 127);
        chk("fwd200_sat", int'(sat_a), 1);
        quad(300, 1'b0, 2);
        wait_sv();
        chk("rev300_speed", int'($signed(speed_a)), -128);
        chk("rev300_sat", int'(sat_a), 1);
        chk("rev300_dir", int'(dir_a), 0);

        // Illegal double transition
        enc_a = ~enc_a;
        enc_b = ~enc_b;
        errs = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            errs += int'(err_a);
        end
        chk("enc_err_pulses", errs, 1);
        wait_sv();
        chk("err_not_counted", int'($signed(speed_a)), 0);

        // Edge decoded in the terminal cycle belongs to the closing window
        repeat (997) @(negedge clk);
        quad(1, 1'b1, 1);
        wait_sv();
        chk("terminal_edge_closing", int'($signed(speed_a)), 1);
        wait_sv();
        chk("terminal_edge_next", int'($signed(speed_a)), 0);

        // Randomized mix checked by the model
        bias = 20;
        for (int c = 0; c < 20000; c++) begin
            if (c % 1500 == 0) bias = $urandom_range(0, 40);
            duty_in    = 8'($urandom_range(0, 255));
            duty_valid = ($urandom_range(0, 29) == 0);
            r = $urandom_range(0, 99);
            ab = {enc_a, enc_b};
            if (r < bias) begin
                ab = pos_ab((gray_pos(ab) + 1) % 4);
            end else if (r < 40) begin
                ab = pos_ab((gray_pos(ab) + 3) % 4);
            end else if (r == 99) begin
                ab = ~ab;
            end
            enc_a = ab[1];
            enc_b = ab[0];
            reset = ($urandom_range(0, 2999) == 0) || (reset && $urandom_range(0, 2) != 0);
            @(negedge clk);
        end
        reset      = 1'b0;
        duty_valid = 1'b0;
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
